// File: rtl/dvp_cam_emu.sv
// DVP (OV7670-style) camera emulator: RGB565 valid/ready stream in, PCLK/VSYNC/HREF/8-bit data out.
// Latency: the first pixel's high byte is on DVP_data one sclk after the pixel is accepted; each byte is held for one PCLK.
// Backpressure: pixel_ready is a 1-sclk pulse once per pixel slot; timing is never stretched, and a missing pixel sends zeros and sets underflow.
module dvp_cam_emu #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        PCLK,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  DVP_data,
  output logic        frame_start,
  output logic        underflow
);

  // PCLK periods per line and the counter widths needed to cover them.
  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = (LINE > 2) ? $clog2(LINE) : 1;
  localparam int VM1  = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int VM2  = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
  localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
  localparam int VW   = (VMAX > 2) ? $clog2(VMAX) : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] VS_LAST   = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST   = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST   = VW'(V_FRONT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VS,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t          r_state;
  logic            r_ph;
  logic [HW-1:0]   r_hcnt;
  logic [VW-1:0]   r_vcnt;
  logic            r_vsync;
  logic            r_href;
  logic [7:0]      r_data;
  logic [7:0]      r_lo;
  logic            r_pixel_ready;
  logic            r_frame_start;
  logic            r_underflow;

  state_t          w_state_nxt;
  logic            w_ph_nxt;
  logic [HW-1:0]   w_hcnt_nxt;
  logic [VW-1:0]   w_vcnt_nxt;
  logic            w_vsync_nxt;
  logic            w_href_nxt;
  logic [7:0]      w_data_nxt;
  logic [7:0]      w_lo_nxt;
  logic            w_ready_nxt;
  logic            w_fs_nxt;
  logic            w_uf_nxt;

  // What the next tick (PCLK falling edge) will move to.
  logic            w_h_wrap;
  logic [HW-1:0]   w_tick_hcnt;
  logic [VW-1:0]   w_tick_vcnt;
  state_t          w_tick_state;
  logic            w_tick_href;
  logic            w_tick_hi;

  // Look ahead to the next tick: line/frame counters and the phase that tick will present.
  always_comb begin
    w_h_wrap     = (r_hcnt == H_LAST);
    w_tick_hcnt  = w_h_wrap ? '0 : r_hcnt + 1'b1;
    w_tick_vcnt  = r_vcnt;
    w_tick_state = r_state;
    if (w_h_wrap) begin
      w_tick_vcnt = r_vcnt + 1'b1;
      case (r_state)
        ST_VS: begin
          if (r_vcnt == VS_LAST) begin
            w_tick_state = ST_VBACK;
            w_tick_vcnt  = '0;
          end
        end
        ST_VBACK: begin
          if (r_vcnt == VB_LAST) begin
            w_tick_state = ST_ACTIVE;
            w_tick_vcnt  = '0;
          end
        end
        ST_ACTIVE: begin
          if (r_vcnt == VA_LAST) begin
            w_tick_state = ST_VFRONT;
            w_tick_vcnt  = '0;
          end
        end
        ST_VFRONT: begin
          if (r_vcnt == VF_LAST) begin
            w_tick_state = enable ? ST_VS : ST_IDLE;
            w_tick_vcnt  = '0;
          end
        end
        default: w_tick_vcnt = '0;
      endcase
    end
    w_tick_href = (w_tick_state == ST_ACTIVE) && (w_tick_hcnt < H_ACT_END);
    // Even byte positions within the active part of the line carry a pixel's high byte.
    w_tick_hi   = w_tick_href && !w_tick_hcnt[0];
  end

  // Next-state and output decode: idle start, PCLK rising half (request pixel), tick (advance and present).
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = 1'b0;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    w_vsync_nxt = r_vsync;
    w_href_nxt  = r_href;
    w_data_nxt  = r_data;
    w_lo_nxt    = r_lo;
    w_ready_nxt = 1'b0;
    w_fs_nxt    = 1'b0;
    w_uf_nxt    = r_underflow;
    if (r_state == ST_IDLE) begin
      w_vsync_nxt = 1'b0;
      w_href_nxt  = 1'b0;
      w_data_nxt  = 8'h00;
      w_hcnt_nxt  = '0;
      w_vcnt_nxt  = '0;
      if (enable) begin
        w_state_nxt = ST_VS;
        w_vsync_nxt = 1'b1;
        w_fs_nxt    = 1'b1;
      end
    end else if (!r_ph) begin
      // PCLK about to rise; ask for a pixel if the coming tick starts one.
      w_ph_nxt    = 1'b1;
      w_ready_nxt = w_tick_hi;
    end else begin
      // Tick: every timing output changes here, so all are stable across PCLK rise.
      w_state_nxt = w_tick_state;
      w_hcnt_nxt  = w_tick_hcnt;
      w_vcnt_nxt  = w_tick_vcnt;
      w_vsync_nxt = (w_tick_state == ST_VS);
      w_href_nxt  = w_tick_href;
      w_fs_nxt    = (r_state == ST_VFRONT) && (w_tick_state == ST_VS);
      if (r_pixel_ready) begin
        if (pixel_valid) begin
          w_data_nxt = pixel_data[15:8];
          w_lo_nxt   = pixel_data[7:0];
        end else begin
          w_data_nxt = 8'h00;
          w_lo_nxt   = 8'h00;
          w_uf_nxt   = 1'b1;
        end
      end else if (w_tick_href) begin
        w_data_nxt = r_lo;
      end else begin
        w_data_nxt = 8'h00;
      end
    end
  end

  // State and output registers; reset drops everything back to idle.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ph          <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_vsync       <= 1'b0;
      r_href        <= 1'b0;
      r_data        <= 8'h00;
      r_lo          <= 8'h00;
      r_pixel_ready <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ph          <= w_ph_nxt;
      r_hcnt        <= w_hcnt_nxt;
      r_vcnt        <= w_vcnt_nxt;
      r_vsync       <= w_vsync_nxt;
      r_href        <= w_href_nxt;
      r_data        <= w_data_nxt;
      r_lo          <= w_lo_nxt;
      r_pixel_ready <= w_ready_nxt;
      r_frame_start <= w_fs_nxt;
      r_underflow   <= w_uf_nxt;
    end
  end

  assign PCLK        = r_ph;
  assign VSYNC       = r_vsync;
  assign HREF        = r_href;
  assign DVP_data    = r_data;
  assign pixel_ready = r_pixel_ready;
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_dvp_cam_emu.sv
// Bench for dvp_cam_emu with a small frame (4x2 active, LINE=12 PCLK, 120 sclk per frame).
// A source driver pushes each slot's expected word; a capture monitor rebuilds words at PCLK rise and pops/compares.
// Frame-level timing and counts are checked by the main sequence after fixed cycle windows.
module tb_dvp_cam_emu;

  logic        sclk;
  logic        rst;
  logic        enable;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        PCLK;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  DVP_data;
  logic        frame_start;
  logic        underflow;

  dvp_cam_emu #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(4),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .sclk(sclk), .rst(rst), .enable(enable),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .DVP_data(DVP_data),
    .frame_start(frame_start), .underflow(underflow)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];

  // Monitor counters, cleared by the main sequence at window starts.
  int n_pclk, n_fs, n_rdy, n_href, n_bytes;
  int vs_len, href_off;
  int cyc = 0;

  // Source state.
  logic [15:0] word = 16'h1234;
  int          slot = 0;
  int          drop_slot = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    n_pclk = 0; n_fs = 0; n_rdy = 0; n_href = 0; n_bytes = 0;
    vs_len = 0; href_off = 0;
  endtask

  // Advance n rising edges, then land just after the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge sclk);
    @(negedge sclk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input logic exp_uf);
    chk({tag, "_frame_start"}, n_fs, 1);
    chk({tag, "_pixel_ready"}, n_rdy, 8);
    chk({tag, "_href_pulses"}, n_href, 2);
    chk({tag, "_bytes"}, n_bytes, 16);
    chk({tag, "_vsync_len"}, vs_len, 24);
    chk({tag, "_href_offset"}, href_off, 48);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
    chk({tag, "_underflow"}, underflow, exp_uf);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_PCLK"}, PCLK, 0);
    chk({tag, "_VSYNC"}, VSYNC, 0);
    chk({tag, "_HREF"}, HREF, 0);
    chk({tag, "_DVP_data"}, DVP_data, 0);
    chk({tag, "_pixel_ready"}, pixel_ready, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_underflow"}, underflow, 0);
  endtask

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial forever begin
    @(posedge sclk);
    cyc++;
  end

  // Source: presents the current word; in a pixel_ready cycle it records what the slot must carry.
  initial forever begin
    @(negedge sclk);
    if (!rst && pixel_ready === 1'b1) begin
      if (slot == drop_slot) begin
        pixel_valid = 1'b0;
        exp_q.push_back(16'h0000);
      end else begin
        pixel_valid = 1'b1;
        pixel_data  = word;
        exp_q.push_back(word);
        word = word + 16'h4444;
      end
      slot++;
    end else begin
      pixel_valid = 1'b1;
      pixel_data  = word;
    end
  end

  // Capture monitor: samples mid-cycle, rebuilds words at PCLK rise, checks line timing.
  initial begin
    logic       p_pclk, p_vsync, p_href, have_hi;
    logic [7:0] p_data, hi;
    int         t_vs, t_rise, t_fall, in_frame;
    p_pclk = 0; p_vsync = 0; p_href = 0; p_data = 0; have_hi = 0; hi = 0;
    t_vs = 0; t_rise = -1; t_fall = 0; in_frame = 0;
    forever begin
      @(negedge sclk);
      if (rst) begin
        have_hi  = 0;
        in_frame = 0;
        t_rise   = -1;
      end else begin
        if (PCLK !== p_pclk) n_pclk++;
        if (frame_start) n_fs++;
        if (pixel_ready) n_rdy++;
        if (!HREF) chk("data_zero_when_href_low", DVP_data, 0);
        if (PCLK && !p_pclk) begin
          chk("data_stable_at_pclk_rise", DVP_data, p_data);
          chk("href_stable_at_pclk_rise", HREF, p_href);
          if (HREF) begin
            n_bytes++;
            if (!have_hi) begin
              hi = DVP_data;
              have_hi = 1;
            end else begin
              have_hi = 0;
              chk("sb_word_expected", exp_q.size() > 0, 1);
              if (exp_q.size() > 0) chk("pixel_word", {hi, DVP_data}, exp_q.pop_front());
            end
          end
        end
        if (VSYNC && !p_vsync) begin
          t_vs = cyc;
          in_frame = 0;
        end
        if (!VSYNC && p_vsync) vs_len = cyc - t_vs;
        if (HREF && !p_href) begin
          n_href++;
          if (in_frame == 0) href_off = cyc - t_vs;
          else chk("href_low_len", cyc - t_fall, 8);
          in_frame++;
          t_rise = cyc;
        end
        if (!HREF && p_href) begin
          if (t_rise >= 0) chk("href_high_len", cyc - t_rise, 16);
          t_fall = cyc;
        end
      end
      p_pclk = PCLK; p_vsync = VSYNC; p_href = HREF; p_data = DVP_data;
    end
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    pixel_valid = 1'b1;
    pixel_data = 16'h1234;
    clr();

    // Reset and idle.
    step(3);
    chk_zero("reset");
    rst = 1'b0;
    step(1);
    clr();
    step(10);
    chk("idle_pclk_toggles", n_pclk, 0);
    chk("idle_pclk", PCLK, 0);
    chk("idle_vsync", VSYNC, 0);

    // Frame 1: always-valid source.
    clr();
    enable = 1'b1;
    step(120);
    chk_frame("f1", 1'b0);

    // Frame 2: third slot starved; enable dropped mid-active, frame still completes.
    clr();
    drop_slot = slot + 2;
    step(60);
    chk("f2_href_mid_active", HREF, 1);
    enable = 1'b0;
    step(60);
    chk_frame("f2", 1'b1);

    // Then idle with PCLK parked low.
    step(2);
    clr();
    step(20);
    chk("idle2_pclk_toggles", n_pclk, 0);
    chk("idle2_pclk", PCLK, 0);
    chk("idle2_vsync", VSYNC, 0);
    chk("idle2_frame_start", n_fs, 0);
    chk("idle2_underflow_sticky", underflow, 1);

    // Frame 3: re-enable gives a new frame; underflow stays set.
    clr();
    enable = 1'b1;
    step(120);
    chk_frame("f3", 1'b1);

    // Frame 4: reset in the middle of the first active line.
    step(60);
    chk("f4_href_before_rst", HREF, 1);
    rst = 1'b1;
    step(1);
    chk_zero("midrst");
    step(2);
    exp_q.delete();
    clr();
    rst = 1'b0;
    step(120);
    chk_frame("post_rst", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
